// File: rtl/ex_ctrl_unit_pkg.sv
// ex_ctrl_unit_pkg
// Shared definitions for the EX-stage control slice: ALU operation codes,
// Control Unit ALUOp classes, RV32I/RV32M funct codes and the
// multiply/divide sequencer state encoding.
// Ports: none (package).
// Configuration macro used by the slice: EX_CTRL_FAST_MUL_EN.
package ex_ctrl_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_LOADSTORE = 2'b00,
    ALUOP_BRANCH    = 2'b01,
    ALUOP_ITYPE     = 2'b10,
    ALUOP_RTYPE     = 2'b11
  } aluop_class_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/ex_ctrl_unit_md_iter.sv
// md_iter_datapath
// Operand/result datapath of the iterative multiply/divide engine. One
// 2*DATA_WIDTH register serves as the shift-add product accumulator for
// multiplies and as {remainder, dividend/quotient} for restoring division.
// Operands are held as magnitudes; signs are reapplied on the way out.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 load operands (FSM accepted an M instruction)
//   i_step_mul, i_step_div  perform one multiply / divide iteration
//   i_funct3                RV32M funct3 of the instruction being started
//   i_rs1_data, i_rs2_data  operands A and B
//   o_special               divide-by-zero or signed overflow (for i_funct3/operands)
//   o_result                sign-fixed, half/quotient/remainder selected result
// Macro EX_CTRL_FAST_MUL_EN: multiplies load the full product at start.
module md_iter_datapath
  import ex_ctrl_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_step_mul,
  input  logic                  i_step_div,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  output logic                  o_special,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_opb;
  logic           r_neg_main;
  logic           r_neg_rem;
  logic [2:0]     r_funct3;

  logic           w_is_div;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic           w_div_zero;
  logic           w_div_ovf;
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [W:0]     w_rem_shift;
  logic [W:0]     w_div_diff;
  logic [2*W-1:0] w_div_next;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0]   w_quo_fix;
  logic [W-1:0]   w_rem_fix;

  // Only MUL/MULH/MULHSU treat rs1 as signed, only MUL/MULH treat rs2 as
  // signed; DIV/REM are signed in both operands, DIVU/REMU in neither.
  assign w_is_div   = i_funct3[2];
  assign w_a_neg    = i_rs1_data[W-1] & (w_is_div ? !i_funct3[0] : (i_funct3 != F3_MULHU));
  assign w_b_neg    = i_rs2_data[W-1] & (w_is_div ? !i_funct3[0] : !i_funct3[1]);
  assign w_abs_a    = w_a_neg ? -i_rs1_data : i_rs1_data;
  assign w_abs_b    = w_b_neg ? -i_rs2_data : i_rs2_data;
  assign w_div_zero = w_is_div && (i_rs2_data == '0);
  assign w_div_ovf  = w_is_div && !i_funct3[0] && (i_rs1_data == MOST_NEG) && (i_rs2_data == '1);
  assign o_special  = w_div_zero | w_div_ovf;

  // Shift-add: multiplier sits in the low half and drains out to the right
  // while partial sums (with carry) enter from the top.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Restoring division: shift the next dividend bit into the remainder and
  // keep the subtraction only when it does not go negative.
  assign w_rem_shift = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_div_diff  = w_rem_shift - {1'b0, r_opb};
  assign w_div_next  = w_div_diff[W] ? {w_rem_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                     : {w_div_diff[W-1:0],  r_acc[W-2:0], 1'b1};

`ifdef EX_CTRL_FAST_MUL_EN
  logic [2*W-1:0] w_fast_prod;
  assign w_fast_prod = {{W{1'b0}}, w_abs_a} * {{W{1'b0}}, w_abs_b};
`endif

  // Operand load and iteration. Special cases preload the architecturally
  // defined raw quotient/remainder with sign fix disabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc      <= '0;
      r_opb      <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_funct3   <= '0;
    end else if (i_start) begin
      r_funct3 <= i_funct3;
      r_opb    <= w_abs_b;
      if (w_div_zero) begin
        r_acc      <= {i_rs1_data, {W{1'b1}}};
        r_neg_main <= 1'b0;
        r_neg_rem  <= 1'b0;
      end else if (w_div_ovf) begin
        r_acc      <= {{W{1'b0}}, i_rs1_data};
        r_neg_main <= 1'b0;
        r_neg_rem  <= 1'b0;
      end else begin
        r_neg_main <= w_a_neg ^ w_b_neg;
        r_neg_rem  <= w_a_neg;
`ifdef EX_CTRL_FAST_MUL_EN
        r_acc      <= w_is_div ? {{W{1'b0}}, w_abs_a} : w_fast_prod;
`else
        r_acc      <= {{W{1'b0}}, w_abs_a};
`endif
      end
    end else if (i_step_mul) begin
      r_acc <= w_mul_next;
    end else if (i_step_div) begin
      r_acc <= w_div_next;
    end
  end

  // Sign fix: product and quotient take the XOR of operand signs, the
  // remainder takes the dividend's sign.
  assign w_prod_fix = r_neg_main ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_main ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_comb begin
    o_result = w_prod_fix[W-1:0];
    if (r_funct3[2]) begin
      o_result = r_funct3[1] ? w_rem_fix : w_quo_fix;
    end else if (r_funct3 != F3_MUL) begin
      o_result = w_prod_fix[2*W-1:W];
    end
  end

endmodule

// File: rtl/ex_ctrl_unit.sv
// ex_ctrl_unit
// EX-stage control: decodes ALUOp/funct7/funct3 into the ALU operation code,
// flags RV32M instructions and sequences the multiply/divide engine with a
// stall handshake towards the pipeline.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid, i_flush        EX instruction valid, pipeline flush (aborts M op)
//   i_alu_op, i_funct7, i_funct3   decode inputs
//   i_rs1_data, i_rs2_data  operands
//   o_alu_op, o_is_md       combinational decode outputs
//   o_stall                 hold IF/ID/EX while an M operation is in flight
//   o_md_done, o_md_result  one-cycle completion pulse and held result
// Macro EX_CTRL_FAST_MUL_EN: single-cycle multiply, divide stays iterative.
module ex_ctrl_unit
  import ex_ctrl_unit_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int CNT_WIDTH    = $clog2(DATA_WIDTH) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic                    i_flush,
  input  logic [1:0]              i_alu_op,
  input  logic [6:0]              i_funct7,
  input  logic [2:0]              i_funct3,
  input  logic [DATA_WIDTH-1:0]   i_rs1_data,
  input  logic [DATA_WIDTH-1:0]   i_rs2_data,
  output logic [ALU_OP_WIDTH-1:0] o_alu_op,
  output logic                    o_is_md,
  output logic                    o_stall,
  output logic                    o_md_done,
  output logic [DATA_WIDTH-1:0]   o_md_result
);

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

  md_state_e             r_state;
  md_state_e             w_next_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_next_cnt;
  logic [DATA_WIDTH-1:0] r_md_result;
  alu_op_e               w_alu_op;
  logic                  w_start;
  logic                  w_done;
  logic                  w_special;
  logic [DATA_WIDTH-1:0] w_dp_result;

  // ALU operation decode. M instructions fall into the R-type default (ADD).
  always_comb begin
    w_alu_op = ALU_ADD;
    case (i_alu_op)
      ALUOP_BRANCH: begin
        case (i_funct3)
          3'b000, 3'b001: w_alu_op = ALU_SUB;
          3'b100, 3'b101: w_alu_op = ALU_SLT;
          3'b110, 3'b111: w_alu_op = ALU_SLTU;
          default:        w_alu_op = ALU_ADD;
        endcase
      end
      ALUOP_ITYPE: begin
        case (i_funct3)
          3'b001:  w_alu_op = ALU_SLL;
          3'b010:  w_alu_op = ALU_SLT;
          3'b011:  w_alu_op = ALU_SLTU;
          3'b100:  w_alu_op = ALU_XOR;
          3'b101:  w_alu_op = (i_funct7 == F7_BASE) ? ALU_SRL :
                              (i_funct7 == F7_ALT)  ? ALU_SRA : ALU_ADD;
          3'b110:  w_alu_op = ALU_OR;
          3'b111:  w_alu_op = ALU_AND;
          default: w_alu_op = ALU_ADD;
        endcase
      end
      ALUOP_RTYPE: begin
        case ({i_funct7, i_funct3})
          {F7_ALT,  3'b000}: w_alu_op = ALU_SUB;
          {F7_BASE, 3'b001}: w_alu_op = ALU_SLL;
          {F7_BASE, 3'b010}: w_alu_op = ALU_SLT;
          {F7_BASE, 3'b011}: w_alu_op = ALU_SLTU;
          {F7_BASE, 3'b100}: w_alu_op = ALU_XOR;
          {F7_BASE, 3'b101}: w_alu_op = ALU_SRL;
          {F7_ALT,  3'b101}: w_alu_op = ALU_SRA;
          {F7_BASE, 3'b110}: w_alu_op = ALU_OR;
          {F7_BASE, 3'b111}: w_alu_op = ALU_AND;
          default:           w_alu_op = ALU_ADD;
        endcase
      end
      default: w_alu_op = ALU_ADD;
    endcase
  end

  assign o_alu_op = ALU_OP_WIDTH'(w_alu_op);
  assign o_is_md  = (i_alu_op == ALUOP_RTYPE) && (i_funct7 == F7_MULDIV);

  assign w_start   = (r_state == ST_IDLE) && i_valid && o_is_md && !i_flush;
  assign w_done    = (r_state == ST_DONE) && !i_flush;
  assign o_stall   = w_start || (r_state == ST_MUL) || (r_state == ST_DIV);
  assign o_md_done = w_done;
  // The fresh result is visible during the done cycle, then held.
  assign o_md_result = w_done ? w_dp_result : r_md_result;

  // State, iteration counter and held result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_md_result <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_done) begin
        r_md_result <= w_dp_result;
      end
    end
  end

  // Next state: the counter runs 0..DATA_WIDTH-1, one datapath step per cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next_cnt = '0;
          if (w_special) begin
            w_next_state = ST_DONE;
          end else if (i_funct3[2]) begin
            w_next_state = ST_DIV;
          end else begin
`ifdef EX_CTRL_FAST_MUL_EN
            w_next_state = ST_DONE;
`else
            w_next_state = ST_MUL;
`endif
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (i_flush) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt + CNT_WIDTH'(1);
          if (r_cnt == LAST_STEP) begin
            w_next_state = ST_DONE;
          end
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  md_iter_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_md_datapath (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_start),
    .i_step_mul (r_state == ST_MUL),
    .i_step_div (r_state == ST_DIV),
    .i_funct3   (i_funct3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .o_special  (w_special),
    .o_result   (w_dp_result)
  );

endmodule

// File: tb/tb_ex_ctrl_unit.sv
// tb_ex_ctrl_unit
// Self-checking bench for ex_ctrl_unit: directed decode vectors and RV32M
// operations, checked every cycle against an arithmetic reference model,
// plus hand-computed literal expectations.
module tb_ex_ctrl_unit;

  localparam int W = 32;
`ifdef EX_CTRL_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        flush;
  logic [1:0]  aluOp;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [3:0]  aluOpOut;
  logic        isMd;
  logic        stall;
  logic        mdDone;
  logic [31:0] mdResult;

  ex_ctrl_unit dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_flush     (flush),
    .i_alu_op    (aluOp),
    .i_funct7    (funct7),
    .i_funct3    (funct3),
    .i_rs1_data  (rs1),
    .i_rs2_data  (rs2),
    .o_alu_op    (aluOpOut),
    .o_is_md     (isMd),
    .o_stall     (stall),
    .o_md_done   (mdDone),
    .o_md_result (mdResult)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle window of the operation in flight, its
  // expected result, and the value the result output must hold otherwise.
  bit          modelOn = 1'b0;
  int          expStart = 0;
  int          expStallUntil = 0;
  int          expDoneAt = -1;
  int          zeroAt = -1;
  logic [31:0] pending = '0;
  logic [31:0] held = '0;
  logic        cmpDone;
  logic        cmpStall;
  logic [31:0] cmpRes;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [6:0] f7,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid  = v;
    aluOp  = op;
    funct7 = f7;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
  endtask

  // ALU op by rule: I-type and base R-type share one funct3 table.
  function automatic logic [3:0] refAluOp(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] baseMap [8];
    baseMap = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    case (op)
      2'b01:   return f3[2] ? (f3[1] ? 4'd4 : 4'd3) : (f3[1] ? 4'd0 : 4'd1);
      2'b10: begin
        if (f3 != 3'b101) return baseMap[f3];
        if (f7 == 7'h00) return 4'd6;
        if (f7 == 7'h20) return 4'd7;
        return 4'd0;
      end
      2'b11: begin
        if (f7 == 7'h00) return baseMap[f3];
        if (f7 == 7'h20 && f3 == 3'b000) return 4'd1;
        if (f7 == 7'h20 && f3 == 3'b101) return 4'd7;
        return 4'd0;
      end
      default: return 4'd0;
    endcase
  endfunction

  function automatic bit isOvf(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] refMd(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    p  = 0;
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : isOvf(f3, a, b) ? a : 32'(ia / ib);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : isOvf(f3, a, b) ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    return (b == 0 || isOvf(f3, a, b)) ? 1 : DIV_LAT;
  endfunction

  task automatic modelStart(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    expStart      = cyc;
    expDoneAt     = cyc + refLatency(f3, a, b);
    expStallUntil = expDoneAt;
    pending       = refMd(f3, a, b);
  endtask

  // Flush/reset in the current cycle: nothing stalls afterwards; a pending
  // completion is lost unless already presented (reset) or at all (flush).
  task automatic modelAbort(input bit isReset);
    if (expStallUntil > cyc + 1) expStallUntil = cyc + 1;
    if (expDoneAt > cyc || (!isReset && expDoneAt == cyc)) expDoneAt = -1;
    if (isReset) zeroAt = cyc + 1;
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (modelOn) begin
      if (cyc == zeroAt) held = '0;
      cmpDone  = (cyc == expDoneAt);
      cmpStall = (cyc >= expStart) && (cyc < expStallUntil);
      cmpRes   = cmpDone ? pending : held;
      checkOutput("stall", 32'(stall), 32'(cmpStall));
      checkOutput("md_done", 32'(mdDone), 32'(cmpDone));
      checkOutput("md_result", mdResult, cmpRes);
      checkOutput("alu_op", 32'(aluOpOut), 32'(refAluOp(aluOp, funct7, funct3)));
      checkOutput("is_md", 32'(isMd), 32'(aluOp == 2'b11 && funct7 == 7'h01));
      if (cmpDone) held = pending;
    end
  end

  task automatic decodeCase(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [3:0] expAlu, input logic expMd);
    applyStimulus(1'b0, op, f7, f3, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("decode alu_op", 32'(aluOpOut), 32'(expAlu));
    checkOutput("decode is_md", 32'(isMd), 32'(expMd));
    @(posedge clk); #1;
  endtask

  // Issue one M instruction and follow it to its done cycle.
  task automatic runMd(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected, output int stallCnt);
    int lat;
    applyStimulus(1'b1, 2'b11, 7'h01, f3, a, b);
    modelStart(f3, a, b);
    lat = expDoneAt - expStart;
    stallCnt = 0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (stall) stallCnt++;
      if (k == lat) begin
        checkOutput({name, " done"}, 32'(mdDone), 32'd1);
        checkOutput({name, " result"}, mdResult, expected);
      end
      @(posedge clk); #1;
      valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc;
    rst   = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    modelOn = 1'b1;
    @(negedge clk);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset md_done", 32'(mdDone), 32'd0);
    checkOutput("reset md_result", mdResult, 32'h0);
    @(posedge clk); #1;

    $display("[TB] ALU decode vectors");
    decodeCase(2'b00, 7'h00, 3'b000, 4'd0, 1'b0);
    decodeCase(2'b00, 7'h20, 3'b101, 4'd0, 1'b0);
    decodeCase(2'b01, 7'h00, 3'b001, 4'd1, 1'b0);
    decodeCase(2'b01, 7'h00, 3'b101, 4'd3, 1'b0);
    decodeCase(2'b01, 7'h00, 3'b110, 4'd4, 1'b0);
    decodeCase(2'b01, 7'h00, 3'b010, 4'd0, 1'b0);
    decodeCase(2'b10, 7'h00, 3'b001, 4'd2, 1'b0);
    decodeCase(2'b10, 7'h00, 3'b101, 4'd6, 1'b0);
    decodeCase(2'b10, 7'h20, 3'b101, 4'd7, 1'b0);
    decodeCase(2'b10, 7'h01, 3'b101, 4'd0, 1'b0);
    decodeCase(2'b10, 7'h00, 3'b111, 4'd9, 1'b0);
    decodeCase(2'b11, 7'h20, 3'b101, 4'd7, 1'b0);
    decodeCase(2'b11, 7'h20, 3'b000, 4'd1, 1'b0);
    decodeCase(2'b11, 7'h00, 3'b110, 4'd8, 1'b0);
    decodeCase(2'b11, 7'h20, 3'b111, 4'd0, 1'b0);
    decodeCase(2'b11, 7'h01, 3'b000, 4'd0, 1'b1);

    $display("[TB] multiply");
    runMd("mul -3*7", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, sc);
    checkOutput("mul stall cycles", 32'(sc), 32'(MUL_LAT));
    runMd("mulhu max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, sc);
    runMd("mulh -3*7", 3'b001, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, sc);
    runMd("mulhsu -1*2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, sc);
    runMd("mulhu 2^31*4", 3'b011, 32'h8000_0000, 32'd4, 32'h0000_0002, sc);
    runMd("mul 2^16*2^16", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0, sc);

    $display("[TB] divide");
    runMd("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, sc);
    checkOutput("div stall cycles", 32'(sc), 32'(DIV_LAT));
    runMd("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, sc);
    runMd("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, sc);
    runMd("remu 100/7", 3'b111, 32'd100, 32'd7, 32'd2, sc);
    runMd("div 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, sc);
    runMd("rem 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, sc);

    $display("[TB] special cases");
    runMd("div 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, sc);
    checkOutput("div0 stall cycles", 32'(sc), 32'd1);
    runMd("rem 5/0", 3'b110, 32'd5, 32'd0, 32'd5, sc);
    runMd("divu 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, sc);
    runMd("remu 5/0", 3'b111, 32'd5, 32'd0, 32'd5, sc);
    runMd("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, sc);
    runMd("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, sc);

    $display("[TB] flush during divide");
    applyStimulus(1'b1, 2'b11, 7'h01, 3'b101, 32'd1000, 32'd3);
    modelStart(3'b101, 32'd1000, 32'd3);
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    modelAbort(1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush stall", 32'(stall), 32'd0);
    checkOutput("flush md_done", 32'(mdDone), 32'd0);
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] reset during multiply");
    applyStimulus(1'b1, 2'b11, 7'h01, 3'b000, 32'd9, 32'd9);
    modelStart(3'b000, 32'd9, 32'd9);
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    modelAbort(1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid reset stall", 32'(stall), 32'd0);
    checkOutput("mid reset md_done", 32'(mdDone), 32'd0);
    checkOutput("mid reset md_result", mdResult, 32'h0);
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] back-to-back");
    runMd("b2b mul 6*7", 3'b000, 32'd6, 32'd7, 32'd42, sc);
    runMd("b2b divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, sc);
    checkOutput("b2b divu stall cycles", 32'(sc), 32'(DIV_LAT));

    repeat (3) @(posedge clk);
    #1;
    modelOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_ctrl_unit.md
Name: ex_ctrl_unit

Overview:
- Parametrised successor of the ALU control decoder for the EX stage.
- Decodes ALUOp/funct7/funct3 into the ALU operation code, as before, and adds RV32M decode.
- Sequences an iterative multiply/divide engine with a stall handshake to the pipeline.
- Sits between the Control Unit, the ALU and the EX/MEM result mux.

Parameters:
- DATA_WIDTH, 32, operand/result width (power of 2, >=8).
- ALU_OP_WIDTH, 4, width of o_alu_op.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  EX-stage instruction valid.
- i_flush  in  1  pipeline flush; aborts any M operation.
- i_alu_op  in  2  ALUOp from Control Unit.
- i_funct7  in  7  instruction funct7.
- i_funct3  in  3  instruction funct3.
- i_rs1_data  in  DATA_WIDTH  operand A.
- i_rs2_data  in  DATA_WIDTH  operand B.
- o_alu_op  out  ALU_OP_WIDTH  ALU operation code (combinational).
- o_is_md  out  1  current instruction is RV32M (combinational).
- o_stall  out  1  hold IF/ID/EX; M operation in flight.
- o_md_done  out  1  one-cycle pulse; o_md_result valid.
- o_md_result  out  DATA_WIDTH  multiply/divide result.

Behaviour:
- ALU op encodings: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- Decode by i_alu_op:
  - 00 -> ADD.
  - 01 (branch), by funct3: 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; else ADD.
  - 10 (I-type), by funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; 101 with funct7 0000000 -> SRL, 0100000 -> SRA, else ADD.
  - 11 (R-type), by {funct7,funct3}: standard RV32I encodings; unlisted codes -> ADD.
- o_is_md = (i_alu_op==11) & (i_funct7==0000001). When o_is_md=1, o_alu_op=ADD (don't-care).
- M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states IDLE, MUL, DIV, DONE; state and counter registered.
- Start condition: IDLE & i_valid & o_is_md & !i_flush.
  - At start, latch absolute operands, result-sign flags and funct3; counter=0.
  - Next state: MUL or DIV; DONE directly for special cases.
- o_stall = start | (state==MUL) | (state==DIV). Combinational, so it is high in the start cycle.
- MUL: one shift-add step per cycle on a 2*DATA_WIDTH accumulator. After DATA_WIDTH steps -> DONE.
- DIV: restoring division, one quotient bit per cycle. After DATA_WIDTH steps -> DONE.
- DONE: apply sign fix and select low/high half (or quotient/remainder) into o_md_result. Assert o_md_done=1 and o_stall=0 for exactly one cycle, then IDLE.
- Latency: start at cycle t -> o_md_done at t+DATA_WIDTH+1. o_md_result holds its value until the next DONE.
- Special cases, detected at start, go straight to DONE (o_md_done at t+1):
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1=most negative, rs2=-1): quotient = rs1; remainder = 0.
- i_flush in MUL/DIV/DONE -> IDLE next cycle. No o_md_done pulse; o_md_result unchanged.
- i_valid is ignored while not IDLE. A new M instruction is accepted only in IDLE.
- Back-to-back M instructions: start is legal on the cycle after DONE.
- Reset: state=IDLE, counter=0, o_md_result=0, o_md_done=0, o_stall=0. Reset mid-operation discards the operation with no o_md_done.

Optional Feature:
- Macro EX_CTRL_FAST_MUL_EN.
- Defined: MUL* computed combinationally with a single 2*DATA_WIDTH signed/unsigned multiply. Start goes straight to DONE (latency 1; o_stall high only in the start cycle). Divide is unchanged.
- Undefined: iterative multiply as above.

Decomposition:
- Shared header alu_defs.vh holds:
  - ALU op localparams;
  - ALUOp codes (LOADSTORE/BRANCH/ITYPE/RTYPE);
  - M funct3 codes;
  - FSM state encodings.
- One sub-module, md_iter_datapath: accumulator/remainder registers, shift-add/subtract step and sign fix. The FSM and decode stay in ex_ctrl_unit.

Test Plan:
- ALU decode sweep: alu_op=11, funct7=0100000, funct3=101 -> o_alu_op=7. alu_op=01, funct3=110 -> 4. alu_op=10, funct3=101, funct7=0000001 -> 0.
- MUL: rs1=-3, rs2=7, funct3=000 -> o_stall high 33 cycles, o_md_done at t+33, result 0xFFFFFFEB. MULHU with 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV/REM: rs1=-7, rs2=2 -> DIV -3 (0xFFFFFFFD), REM -1. DIVU 100/7 -> 14; REMU -> 2.
- Special cases: DIV 5/0 -> 0xFFFFFFFF at t+1. REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Flush/reset: i_flush at t+10 of a DIV -> IDLE at t+11, no done pulse, o_stall low. i_rst at t+5 -> all outputs at reset values the next cycle.
- Back-to-back: MUL then DIVU issued the cycle after done -> second done exactly 33 cycles after its start. With EX_CTRL_FAST_MUL_EN: MUL done at t+1.
